// File: rtl/program_loader_if.sv
// Host-byte / program-memory-write bundle for the program loader.
// The master modport drives the host side; the slave modport belongs to the loader.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 14
);
    logic              load_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [DATA_W-1:0] pm_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_req, rx_data, rx_valid,
        input  pm_we, pm_addr, pm_data, cpu_hold, busy, done, err
    );

    modport slave (
        input  load_req, rx_data, rx_valid,
        output pm_we, pm_addr, pm_data, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/program_loader.sv
// Assembles 14-bit instruction words from a host byte stream and writes them
// to sequential program-memory addresses, holding the core while a load runs.
module program_loader #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned MAX_WORDS = 2048
) (
    input  logic                clk,
    input  logic                rst,
    program_loader_if.slave     bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, W_HI, W_LO, CHK, DONE, ERR
    } state_t;

    state_t            state, state_nxt;
    logic              start_c;
    logic              accept_c;
    logic              wr_word_c;
    logic [15:0]       count_in_c;

    logic [7:0]        cnt_hi;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  word_cnt;
    logic [5:0]        word_hi;
    logic [7:0]        sum;
    logic              pm_we;
    logic [DATA_W-1:0] pm_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    assign count_in_c = {cnt_hi, bus.rx_data};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and per-byte strobes
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        accept_c  = 1'b0;
        wr_word_c = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.load_req) begin
                    state_nxt = CNT_HI;
                    start_c   = 1'b1;
                end
            end
            CNT_HI: begin
                if (bus.rx_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = CNT_LO;
                end
            end
            CNT_LO: begin
                if (bus.rx_valid) begin
                    accept_c = 1'b1;
                    if (count_in_c > 16'(MAX_WORDS)) state_nxt = ERR;
                    else if (count_in_c == 16'd0)    state_nxt = CHK;
                    else                             state_nxt = W_HI;
                end
            end
            W_HI: begin
                if (bus.rx_valid) begin
                    accept_c = 1'b1;
                    if (bus.rx_data[7:6] != 2'b00) state_nxt = ERR;
                    else                           state_nxt = W_LO;
                end
            end
            W_LO: begin
                if (bus.rx_valid) begin
                    accept_c  = 1'b1;
                    wr_word_c = 1'b1;
                    // word_cnt advances only after the write pulse, so +1 is this word
                    if (CNT_W'(word_cnt + 1'b1) == count) state_nxt = CHK;
                    else                                  state_nxt = W_HI;
                end
            end
            CHK: begin
                if (bus.rx_valid) begin
                    accept_c = 1'b1;
                    if (8'(sum + bus.rx_data) == 8'h00) state_nxt = DONE;
                    else                                state_nxt = ERR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, write port and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_hi   <= '0;
            count    <= '0;
            word_cnt <= '0;
            word_hi  <= '0;
            sum      <= '0;
            pm_we    <= 1'b0;
            pm_data  <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            pm_we <= wr_word_c;
            if (wr_word_c) pm_data <= DATA_W'({word_hi, bus.rx_data});
            if (start_c) begin
                sum      <= '0;
                word_cnt <= '0;
            end else begin
                if (accept_c) sum      <= 8'(sum + bus.rx_data);
                if (pm_we)    word_cnt <= CNT_W'(word_cnt + 1'b1);
            end
            if (accept_c && state == CNT_HI) cnt_hi  <= bus.rx_data;
            if (accept_c && state == CNT_LO) count   <= CNT_W'(count_in_c);
            if (accept_c && state == W_HI)   word_hi <= bus.rx_data[5:0];
            busy     <= !(state_nxt inside {IDLE, DONE, ERR});
            cpu_hold <= !(state_nxt inside {IDLE, DONE, ERR});
            done     <= (state_nxt == DONE);
            err      <= (state_nxt == ERR);
        end
    end

    assign bus.pm_we    = pm_we;
    assign bus.pm_addr  = word_cnt[ADDR_W-1:0];
    assign bus.pm_data  = pm_data;
    assign bus.cpu_hold = cpu_hold;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed loads, checksum/count/word errors,
// mid-frame load_req, byte gaps and reset during a load.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst;

    program_loader_if bus ();

    program_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int gap_sel = 0;

    logic [7:0]  frame_q[$];
    logic [10:0] wr_addr_q[$];
    logic [13:0] wr_data_q[$];

    // Record every program-memory write seen mid-cycle
    always @(negedge clk) begin
        if (bus.pm_we) begin
            wr_addr_q.push_back(bus.pm_addr);
            wr_data_q.push_back(bus.pm_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat (gap_sel % 6) tick();
        gap_sel++;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) send_byte(frame_q[i]);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_two_words(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            chk({tag, "_a0"}, 32'(wr_addr_q[0]), 32'h0);
            chk({tag, "_d0"}, 32'(wr_data_q[0]), 32'h0103);
            chk({tag, "_a1"}, 32'(wr_addr_q[1]), 32'h1);
            chk({tag, "_d1"}, 32'(wr_data_q[1]), 32'h3028);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_we"},   32'(bus.pm_we),    32'd0);
        chk({tag, "_addr"}, 32'(bus.pm_addr),  32'd0);
        chk({tag, "_data"}, 32'(bus.pm_data),  32'd0);
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy),     32'd0);
        chk({tag, "_done"}, 32'(bus.done),     32'd0);
        chk({tag, "_err"},  32'(bus.err),      32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.load_req = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        check_idle_outputs("rst");
        rst = 1'b0;
        tick();

        // Test 1: two-word load, good checksum, mid-frame load_req ignored
        clear_log();
        pulse_load();
        chk("t1_hold", 32'(bus.cpu_hold), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        frame_q = '{8'h00, 8'h02, 8'h01, 8'h03};
        send_frame();
        pulse_load();
        chk("t1_busy_mid", 32'(bus.busy), 32'd1);
        frame_q = '{8'h30, 8'h28};
        send_frame();
        chk("t1_not_done", 32'(bus.done), 32'd0);
        frame_q = '{8'hA2};
        send_frame();
        check_two_words("t1");
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_err",  32'(bus.err),  32'd0);
        chk("t1_hold_off", 32'(bus.cpu_hold), 32'd0);
        chk("t1_busy_off", 32'(bus.busy), 32'd0);
        chk("t1_addr", 32'(bus.pm_addr), 32'd2);

        // Test 2: N=0 started with a simultaneous byte that must be dropped
        clear_log();
        bus.load_req = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hFF;
        tick();
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        chk("t2_done_clr", 32'(bus.done), 32'd0);
        chk("t2_addr_clr", 32'(bus.pm_addr), 32'd0);
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame();
        chk("t2_nwr", 32'(wr_addr_q.size()), 32'd0);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_err",  32'(bus.err),  32'd0);

        // Test 3: bad checksum after both words written
        clear_log();
        pulse_load();
        frame_q = '{8'h00, 8'h02, 8'h01, 8'h03, 8'h30, 8'h28, 8'hA3};
        send_frame();
        check_two_words("t3");
        chk("t3_err",  32'(bus.err),  32'd1);
        chk("t3_done", 32'(bus.done), 32'd0);
        chk("t3_hold", 32'(bus.cpu_hold), 32'd0);

        // Test 4: W_HI with bit6 set aborts at once; later bytes ignored
        clear_log();
        pulse_load();
        chk("t4_err_clr", 32'(bus.err), 32'd0);
        frame_q = '{8'h00, 8'h01, 8'h41};
        send_frame();
        chk("t4_err", 32'(bus.err), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        frame_q = '{8'h03, 8'hBB};
        send_frame();
        repeat (2) tick();
        chk("t4_nwr", 32'(wr_addr_q.size()), 32'd0);
        chk("t4_err_hold", 32'(bus.err), 32'd1);
        chk("t4_done", 32'(bus.done), 32'd0);

        // Test 5: count 2049 rejected, count 2048 accepted
        clear_log();
        pulse_load();
        frame_q = '{8'h08, 8'h01};
        send_frame();
        chk("t5_err", 32'(bus.err), 32'd1);
        chk("t5_hold", 32'(bus.cpu_hold), 32'd0);
        chk("t5_nwr", 32'(wr_addr_q.size()), 32'd0);
        pulse_load();
        frame_q = '{8'h08, 8'h00};
        send_frame();
        chk("t5_max_busy", 32'(bus.busy), 32'd1);
        chk("t5_max_err",  32'(bus.err),  32'd0);

        // Test 6: reset after the first word of a load, then a clean reload
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_log();
        pulse_load();
        frame_q = '{8'h00, 8'h02, 8'h01, 8'h03};
        send_frame();
        tick();
        chk("t6_nwr_pre", 32'(wr_addr_q.size()), 32'd1);
        chk("t6_addr_pre", 32'(bus.pm_addr), 32'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("t6_rst");
        tick();
        rst = 1'b0;
        tick();
        clear_log();
        pulse_load();
        frame_q = '{8'h00, 8'h02, 8'h01, 8'h03, 8'h30, 8'h28, 8'hA2};
        send_frame();
        check_two_words("t6");
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_err",  32'(bus.err),  32'd0);
        chk("t6_addr", 32'(bus.pm_addr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
